// File: rtl/pwm_trip_ctrl.sv
// pwm_trip_ctrl: output-stage trip protection for the eight pwm_16bits outputs
module pwm_trip_ctrl #(
   parameter int N_CH          = 4,
   parameter int FILT_WIDTH    = 8,
   parameter int TRIPCNT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_CH-1:0]          pwm_in_A,
   input  logic [N_CH-1:0]          pwm_in_B,
   input  logic                     cycle_start,
   input  logic                     fault_n,
   input  logic                     trip_sw,
   input  logic                     trip_en,
   input  logic                     trip_mode,
   input  logic [FILT_WIDTH-1:0]    filt_len,
   input  logic [N_CH-1:0]          safe_A,
   input  logic [N_CH-1:0]          safe_B,
   input  logic                     trip_clear,
   output logic [N_CH-1:0]          pwm_out_A,
   output logic [N_CH-1:0]          pwm_out_B,
   output logic                     tripped,
   output logic                     trip_irq,
   output logic [TRIPCNT_WIDTH-1:0] trip_count
);
   typedef enum logic [1:0] {ARMED, TRIP_OSHT, TRIP_CBC} state_t;
   state_t                   r_state;
   logic                     r_sync1;
   logic                     r_sync2;
   logic [FILT_WIDTH-1:0]    r_filt_cnt;
   logic                     r_irq;
   logic [TRIPCNT_WIDTH-1:0] r_count;
   logic                     w_fault_qual;
   logic                     w_trip_req;
   logic                     w_safe;
   assign w_fault_qual = r_sync2 && (r_filt_cnt >= filt_len);
   assign w_trip_req   = trip_en && (w_fault_qual || trip_sw);
   assign w_safe       = reset || (r_state != ARMED);
   assign pwm_out_A    = w_safe ? safe_A : pwm_in_A;
   assign pwm_out_B    = w_safe ? safe_B : pwm_in_B;
   assign tripped      = r_state != ARMED;
   assign trip_irq     = r_irq;
   assign trip_count   = r_count;
   // two-flop synchroniser for the active-low asynchronous fault pin
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= ~fault_n;
         r_sync2 <= r_sync1;
      end
   end
   // glitch filter: counts consecutive synced fault cycles, saturating
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_filt_cnt <= '0;
      else
         r_filt_cnt <= !r_sync2 ? '0 : (&r_filt_cnt) ? r_filt_cnt : r_filt_cnt + FILT_WIDTH'(1);
   end
   // trip state machine with registered interrupt pulse and saturating event counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ARMED;
         r_irq   <= 1'b0;
         r_count <= '0;
      end else begin
         r_irq <= 1'b0;
         case (r_state)
            ARMED: if (w_trip_req) begin
               r_state <= (trip_sw || !trip_mode) ? TRIP_OSHT : TRIP_CBC;
               r_irq   <= 1'b1;
               r_count <= (&r_count) ? r_count : r_count + TRIPCNT_WIDTH'(1);
            end
            TRIP_OSHT: if (trip_clear && !w_trip_req) r_state <= ARMED;
            TRIP_CBC:
               if (trip_sw)
                  r_state <= TRIP_OSHT;
               else if ((cycle_start && !w_fault_qual) || (trip_clear && !w_trip_req))
                  r_state <= ARMED;
            default: r_state <= ARMED;
         endcase
      end
   end
endmodule

// File: tb/tb_pwm_trip_ctrl.sv
// tb_pwm_trip_ctrl: directed stimulus, behavioural model compared every cycle, plus literal pins
module tb_pwm_trip_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] pwm_in_A = '0, pwm_in_B = '0, safe_A = 4'b0011, safe_B = 4'b1100;
   logic       cycle_start = 0, fault_n = 1, trip_sw = 0, trip_en = 1, trip_mode = 0, trip_clear = 0;
   logic [7:0] filt_len = 8'd3;
   logic [3:0] pwm_out_A, pwm_out_B;
   logic       tripped, trip_irq;
   logic [15:0] trip_count;
   int n_cmp = 0;
   int n_bad = 0;

   pwm_trip_ctrl #(.N_CH(4), .FILT_WIDTH(8), .TRIPCNT_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .pwm_in_A(pwm_in_A), .pwm_in_B(pwm_in_B),
      .cycle_start(cycle_start), .fault_n(fault_n), .trip_sw(trip_sw), .trip_en(trip_en),
      .trip_mode(trip_mode), .filt_len(filt_len), .safe_A(safe_A), .safe_B(safe_B),
      .trip_clear(trip_clear), .pwm_out_A(pwm_out_A), .pwm_out_B(pwm_out_B),
      .tripped(tripped), .trip_irq(trip_irq), .trip_count(trip_count)
   );

   always #5 clk = ~clk;

   // model: fault history as a delay line plus a run length, trip as 0=none 1=latched 2=cycle-by-cycle
   logic m_s1 = 0, m_s2 = 0, m_irq = 0;
   int   m_run = 0, m_trip = 0, m_count = 0;
   logic m_qual, m_req, m_new;
   int   m_next;

   always_comb begin
      m_qual = m_s2 && (m_run >= int'(filt_len));
      m_req  = trip_en && (m_qual || trip_sw);
      m_next = m_trip;
      m_new  = 1'b0;
      if (m_trip == 0 && m_req) begin
         m_next = (trip_sw || !trip_mode) ? 1 : 2;
         m_new  = 1'b1;
      end else if (m_trip == 1 && trip_clear && !m_req)
         m_next = 0;
      else if (m_trip == 2) begin
         if (trip_sw) m_next = 1;
         else if ((cycle_start && !m_qual) || (trip_clear && !m_req)) m_next = 0;
      end
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_s1 <= 0; m_s2 <= 0; m_run <= 0; m_trip <= 0; m_count <= 0; m_irq <= 0;
      end else begin
         m_trip  <= m_next;
         m_irq   <= m_new;
         m_count <= (m_new && m_count < 65535) ? m_count + 1 : m_count;
         m_run   <= m_s2 ? ((m_run < 255) ? m_run + 1 : 255) : 0;
         m_s2    <= m_s1;
         m_s1    <= !fault_n;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // compare process: DUT against model on every falling edge
   always @(negedge clk) begin
      check("model_out_A", 32'(pwm_out_A), 32'((reset || m_trip != 0) ? safe_A : pwm_in_A));
      check("model_out_B", 32'(pwm_out_B), 32'((reset || m_trip != 0) ? safe_B : pwm_in_B));
      check("model_tripped", 32'(tripped), 32'(m_trip != 0));
      check("model_irq", 32'(trip_irq), 32'(m_irq));
      check("model_count", 32'(trip_count), 32'(m_count));
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      @(negedge clk);
      check("rst_out_A", 32'(pwm_out_A), 32'h3);
      check("rst_out_B", 32'(pwm_out_B), 32'hC);
      check("rst_tripped", 32'(tripped), 0);
      tick(1);
      reset = 0; pwm_in_A = 4'b0101; pwm_in_B = 4'b1010;
      #1;
      check("pass_A", 32'(pwm_out_A), 32'h5);
      check("pass_B", 32'(pwm_out_B), 32'hA);
      tick(1);
      pwm_in_A = 4'b1010; pwm_in_B = 4'b0101;
      #1;
      check("pass2_A", 32'(pwm_out_A), 32'hA);
      check("pass_count", 32'(trip_count), 0);
      safe_A = 4'b0000; safe_B = 4'b0000;
      tick(1);
      fault_n = 0; tick(3); fault_n = 1; tick(8);
      check("short_pulse", 32'(tripped), 0);
      fault_n = 0;
      repeat (5) @(posedge clk);
      #1;
      check("lat_before", 32'(tripped), 0);
      tick(1);
      check("lat_tripped", 32'(tripped), 1);
      check("lat_out_A", 32'(pwm_out_A), 0);
      check("lat_irq", 32'(trip_irq), 1);
      check("lat_count", 32'(trip_count), 1);
      tick(1);
      check("lat_irq_end", 32'(trip_irq), 0);
      tick(4);
      trip_clear = 1; tick(1); trip_clear = 0;
      check("clr_ignored", 32'(tripped), 1);
      fault_n = 1; tick(4);
      trip_clear = 1; tick(1); trip_clear = 0;
      check("clr_ok", 32'(tripped), 0);
      check("clr_pass", 32'(pwm_out_A), 32'hA);
      trip_mode = 1; filt_len = 0;
      fault_n = 0; tick(2);
      check("cbc_before", 32'(tripped), 0);
      tick(1);
      check("cbc_trip", 32'(tripped), 1);
      check("cbc_count", 32'(trip_count), 2);
      tick(17);
      fault_n = 1; cycle_start = 1; tick(1); cycle_start = 0;
      check("cbc_hold", 32'(tripped), 1);
      tick(4);
      check("cbc_hold2", 32'(tripped), 1);
      cycle_start = 1; tick(1); cycle_start = 0;
      check("cbc_release", 32'(tripped), 0);
      check("cbc_pass_B", 32'(pwm_out_B), 32'h5);
      fault_n = 0; tick(3);
      check("cbc2_count", 32'(trip_count), 3);
      fault_n = 1; tick(4);
      trip_sw = 1; tick(1); trip_sw = 0;
      check("esc_tripped", 32'(tripped), 1);
      check("esc_no_irq", 32'(trip_irq), 0);
      check("esc_count", 32'(trip_count), 3);
      cycle_start = 1; tick(1); cycle_start = 0;
      check("esc_cs_hold", 32'(tripped), 1);
      trip_clear = 1; tick(1); trip_clear = 0;
      check("esc_clear", 32'(tripped), 0);
      trip_mode = 0;
      trip_sw = 1; tick(1);
      check("sw_count", 32'(trip_count), 4);
      trip_clear = 1; tick(1);
      check("trip_beats_clear", 32'(tripped), 1);
      trip_sw = 0; tick(1); trip_clear = 0;
      check("sim_release", 32'(tripped), 0);
      trip_sw = 1; tick(1);
      check("retrip_irq", 32'(trip_irq), 1);
      check("retrip_count", 32'(trip_count), 5);
      safe_A = 4'b1001; safe_B = 4'b0110;
      reset = 1; #1;
      check("mid_rst_A", 32'(pwm_out_A), 32'h9);
      check("mid_rst_B", 32'(pwm_out_B), 32'h6);
      check("mid_rst_count", 32'(trip_count), 0);
      trip_sw = 0; tick(2);
      reset = 0; tick(1);
      check("post_rst_pass", 32'(pwm_out_A), 32'hA);
      check("post_rst_tripped", 32'(tripped), 0);
      trip_en = 0; fault_n = 0; tick(50);
      check("en_block_fault", 32'(tripped), 0);
      trip_sw = 1; tick(2); trip_sw = 0;
      check("en_block_sw", 32'(tripped), 0);
      check("en_block_count", 32'(trip_count), 0);
      fault_n = 1; tick(4); trip_en = 1; tick(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
